fetch_queue: RTL



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fq_fifo.sv | 80 ++++++++
 rtl/fetch_queue.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch front end.
//   NOP_INST   - canonical RISC-V NOP (addi x0, x0, 0) shown when the queue is empty
//   XLEN       - PC width used by the queue entry type
//   fq_entry_t - one buffered fetch: instruction word plus the PC it was fetched from
package fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: synchronous FIFO of fq_entry_t with flush.
// Ports:
//   clk_i, reset_i  - clock, synchronous active-high reset
//   flush_i         - clears pointers and count; beats enq_i/deq_i in the same cycle
//   enq_i, enq_data_i - push at tail
//   deq_i           - pop head (caller guarantees non-empty)
//   head_o          - entry at the head slot (meaningless when count_o == 0)
//   count_o         - number of stored entries, 0..Depth
// Depth must be a power of two so the pointers wrap naturally.
module fq_fifo import fetch_pkg::*; #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            enq_i,
  input  fq_entry_t       enq_data_i,
  input  logic            deq_i,
  output fq_entry_t       head_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  fq_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (deq_i) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({enq_i, deq_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (enq_i && !flush_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

`ifndef SYNTHESIS
  // The issue throttle upstream must never let a push land on a full queue.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i && enq_i && !deq_i) begin
      assert (count_q != DepthC) else $error("fq_fifo: push into full queue");
    end
  end
`endif

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Issues reads to a synchronous
// instruction memory (data returns one cycle after an enabled issue), buffers
// returned words with their PCs, and presents the head to IF/ID.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   imem_en, imem_addr    - memory read request (word address)
//   imem_rdata            - memory read data, one cycle after imem_en
//   redirect, redirect_pc - flush stale fetches and restart at redirect_pc
//   deq_ready             - consumer takes the head this cycle
//   inst_valid, inst, inst_pc - head entry (NOP / 0 when empty)
// Optional macro FETCH_PERF_EN adds perf_full_cycles and perf_redirects.
// XLEN must equal fetch_pkg::XLEN since the queue entry type is fixed there.
module fetch_queue import fetch_pkg::*; #(
  parameter int unsigned    XLEN      = 64,
  parameter int unsigned    DEPTH     = 4,
  parameter int unsigned    ADDR_BITS = 14,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_en,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirect_pc,
  input  logic                 deq_ready,
  output logic                 inst_valid,
  output logic [31:0]          inst,
  output logic [XLEN-1:0]      inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_full_cycles,
  output logic [31:0]          perf_redirects
`endif
);

  localparam int unsigned     CntW   = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic            pending_q, pending_d;
  logic [XLEN-1:0] issue_pc;
  logic [CntW-1:0] count, occupancy;
  logic            issue, enq, deq_fire;
  fq_entry_t       head, enq_data;
  logic            unused_pc_lsbs;

  // Redirect targets are forced word-aligned; the low bits are simply dropped.
  assign issue_pc       = redirect ? {redirect_pc[XLEN-1:2], 2'b00} : fetch_pc_q;
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Stored entries plus the one in flight must fit, so a response can always enqueue.
  assign occupancy = count + CntW'(pending_q);
  assign issue     = !reset && (redirect || (occupancy < DepthC));

  assign imem_en   = issue;
  assign imem_addr = issue_pc[ADDR_BITS+1:2];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    pending_d  = 1'b0;
    if (issue) begin
      fetch_pc_d = issue_pc + XLEN'(4);
      rsp_pc_d   = issue_pc;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= '0;
      pending_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      pending_q  <= pending_d;
    end
  end

  // A response arriving in a redirect cycle belongs to the old path.
  assign enq           = pending_q && !redirect;
  assign enq_data.inst = imem_rdata;
  assign enq_data.pc   = rsp_pc_q;

  assign inst_valid = (count != '0);
  assign deq_fire   = inst_valid && deq_ready && !redirect;

  fq_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .flush_i    (redirect),
    .enq_i      (enq),
    .enq_data_i (enq_data),
    .deq_i      (deq_fire),
    .head_o     (head),
    .count_o    (count)
  );

  assign inst    = inst_valid ? head.inst : NOP_INST;
  assign inst_pc = inst_valid ? head.pc   : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_full_q, perf_full_d;
  logic [31:0] perf_redir_q, perf_redir_d;

  always_comb begin
    perf_full_d  = perf_full_q;
    perf_redir_d = perf_redir_q;
    if ((occupancy == DepthC) && !redirect && (perf_full_q != '1)) begin
      perf_full_d = perf_full_q + 32'd1;
    end
    if (redirect && (perf_redir_q != '1)) begin
      perf_redir_d = perf_redir_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_full_q  <= '0;
      perf_redir_q <= '0;
    end else begin
      perf_full_q  <= perf_full_d;
      perf_redir_q <= perf_redir_d;
    end
  end

  assign perf_full_cycles = perf_full_q;
  assign perf_redirects   = perf_redir_q;
`endif

endmodule
